// File: rtl/bcd_preset_counter_pkg.sv
// Shared BCD constants and elaboration-time conversion helpers for the preset counter.
package bcd_preset_counter_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Binary integer to packed BCD (digit 0 in bits [3:0]), up to 16 digits.
  function automatic logic [63:0] to_bcd(input int value, input int digits);
    logic [63:0] r;
    int          v;
    r = 64'd0;
    v = value;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end else begin
        r[4*i +: 4] = 4'd0;
      end
    end
    return r;
  endfunction

  // Packed BCD to binary integer; digits above 9 give a value that is not meaningful.
  function automatic int bcd_to_int(input logic [63:0] bcd, input int digits);
    int acc;
    acc = 0;
    for (int i = 15; i >= 0; i--) begin
      if (i < digits) begin
        acc = acc * 10 + int'(bcd[4*i +: 4]);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_preset_counter_digit.sv
// One BCD digit of next-state logic: clear, load, increment with carry, decrement with borrow.
module bcd_digit
  import bcd_preset_counter_pkg::*;
(
  input  logic [3:0] value,
  input  logic       inc,
  input  logic       dec,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] next_value,
  output logic       carry_out,
  output logic       borrow_out
);

  assign carry_out  = inc & (value == BCD_MAX);
  assign borrow_out = dec & (value == 4'd0);

  // Select the digit's next value; clear beats load beats inc beats dec.
  always_comb begin
    next_value = value;
    if (clear) begin
      next_value = 4'd0;
    end else if (load) begin
      next_value = load_val;
    end else if (inc) begin
      next_value = (value == BCD_MAX) ? 4'd0 : value + 4'd1;
    end else if (dec) begin
      next_value = (value == 4'd0) ? BCD_MAX : value - 4'd1;
    end else begin
      next_value = value;
    end
  end

endmodule

// File: rtl/bcd_preset_counter.sv
// Multi-digit BCD up/down counter with validated, edge-triggered preset load.
module bcd_preset_counter
  import bcd_preset_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MODULO = 30,
  parameter int WRAP   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  enable,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  terminal,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int             W         = BCD_W * DIGITS;
  localparam logic [63:0]    TERM_FULL = to_bcd(MODULO - 1, DIGITS);
  localparam logic [W-1:0]   TERM_BCD  = TERM_FULL[W-1:0];
  localparam logic           WRAP_EN   = (WRAP != 0);

  logic [W-1:0]    count_r;
  logic            wrap_r;
  logic            load_err_r;
  logic            load_q;
  logic            load_edge;
  logic            preset_ok;
  logic            load_apply;
  logic            count_step;
  logic            step_up;
  logic            step_down;
  logic            wrap_up;
  logic            wrap_down;
  logic [W-1:0]    next_count;
  logic [DIGITS:0] inc_chain;
  logic [DIGITS:0] dec_chain;
  logic            chain_unused;

  assign count    = count_r;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;
  assign terminal = up ? (count_r == TERM_BCD) : (count_r == {W{1'b0}});

  // A held load request acts only once; load_q clears on reset so a level held
  // across reset release still produces one load.
  assign load_edge  = load & ~load_q;
  assign load_apply = load_edge & preset_ok;

  // A load edge takes precedence over counting, so enable is ignored on that cycle.
  assign count_step = enable & ~load_edge;
  assign step_up    = count_step &  up & ~terminal;
  assign step_down  = count_step & ~up & ~terminal;
  assign wrap_up    = count_step &  up & terminal & WRAP_EN;
  assign wrap_down  = count_step & ~up & terminal & WRAP_EN;

  // Preset is accepted only if every digit is decimal and the value is in range.
  always_comb begin
    preset_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (preset[4*i +: 4] > BCD_MAX) begin
        preset_ok = 1'b0;
      end else begin
        preset_ok = preset_ok;
      end
    end
    if (bcd_to_int(64'(preset), DIGITS) >= MODULO) begin
      preset_ok = 1'b0;
    end else begin
      preset_ok = preset_ok;
    end
  end

  assign inc_chain[0] = step_up;
  assign dec_chain[0] = step_down;

  // Carry/borrow ripple from digit 0 upward; a down-wrap reuses the load path with MODULO-1.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .value      (count_r[4*g +: 4]),
      .inc        (inc_chain[g]),
      .dec        (dec_chain[g]),
      .clear      (wrap_up),
      .load       (load_apply | wrap_down),
      .load_val   (load_apply ? preset[4*g +: 4] : TERM_BCD[4*g +: 4]),
      .next_value (next_count[4*g +: 4]),
      .carry_out  (inc_chain[g+1]),
      .borrow_out (dec_chain[g+1])
    );
  end

  // Carry/borrow out of the top digit never occurs inside the counting range.
  assign chain_unused = inc_chain[DIGITS] ^ dec_chain[DIGITS];

  // State and output registers; reset has top priority and clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r    <= {W{1'b0}};
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      load_q     <= load;
      count_r    <= next_count;
      wrap_r     <= wrap_up | wrap_down;
      load_err_r <= load_edge & ~preset_ok;
    end
  end

endmodule

// File: tb/tb_bcd_preset_counter.sv
// Directed self-checking bench for bcd_preset_counter (2 digits, mod 30, wrap and hold variants).
module tb_bcd_preset_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] preset;
  logic       enable;
  logic       up;
  logic [7:0] count_w, count_h;
  logic       terminal_w, terminal_h;
  logic       wrap_w, wrap_h;
  logic       load_err_w, load_err_h;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_preset_counter #(.DIGITS(2), .MODULO(30), .WRAP(1)) dut_w (
    .clock(clock), .reset(reset), .load(load), .preset(preset), .enable(enable), .up(up),
    .count(count_w), .terminal(terminal_w), .wrap(wrap_w), .load_err(load_err_w)
  );

  bcd_preset_counter #(.DIGITS(2), .MODULO(30), .WRAP(0)) dut_h (
    .clock(clock), .reset(reset), .load(load), .preset(preset), .enable(enable), .up(up),
    .count(count_h), .terminal(terminal_h), .wrap(wrap_h), .load_err(load_err_h)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; preset = 8'h00; enable = 1'b0; up = 1'b1;
    tick(); tick();
    n_checks++; if (count_w !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", count_w); end
    n_checks++; if (wrap_w !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap_w); end
    n_checks++; if (load_err_w !== 1'b0) begin n_fail++; $display("FAIL reset_load_err got=%b exp=0", load_err_w); end
    n_checks++; if (terminal_w !== 1'b0) begin n_fail++; $display("FAIL reset_terminal_up got=%b exp=0", terminal_w); end
    up = 1'b0; #1;
    n_checks++; if (terminal_w !== 1'b1) begin n_fail++; $display("FAIL reset_terminal_down got=%b exp=1", terminal_w); end
    reset = 1'b0; up = 1'b1;
    tick();
    n_checks++; if (count_w !== 8'h00) begin n_fail++; $display("FAIL idle_count got=%h exp=00", count_w); end
  endtask

  task automatic test_load_held();
    preset = 8'h25; load = 1'b1; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (count_w !== 8'h25) begin n_fail++; $display("FAIL load_held_count[%0d] got=%h exp=25", i, count_w); end
      n_checks++; if (load_err_w !== 1'b0) begin n_fail++; $display("FAIL load_held_err[%0d] got=%b exp=0", i, load_err_w); end
      preset = 8'h11;  // a second load would show up as 11
    end
    load = 1'b0;
    tick();
    n_checks++; if (count_w !== 8'h25) begin n_fail++; $display("FAIL load_release_count got=%h exp=25", count_w); end
  endtask

  task automatic test_count_up_wrap();
    logic [7:0] exp_c [4] = '{8'h28, 8'h29, 8'h00, 8'h01};
    logic       exp_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    preset = 8'h27; load = 1'b1; up = 1'b1; enable = 1'b0;
    tick();
    n_checks++; if (count_w !== 8'h27) begin n_fail++; $display("FAIL up_load got=%h exp=27", count_w); end
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (count_w !== exp_c[i]) begin n_fail++; $display("FAIL up_count[%0d] got=%h exp=%h", i, count_w, exp_c[i]); end
      n_checks++; if (terminal_w !== exp_t[i]) begin n_fail++; $display("FAIL up_terminal[%0d] got=%b exp=%b", i, terminal_w, exp_t[i]); end
      n_checks++; if (wrap_w !== exp_w[i]) begin n_fail++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap_w, exp_w[i]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_count_down_wrap_hold();
    logic [7:0] exp_c [3] = '{8'h00, 8'h29, 8'h28};
    logic       exp_w [3] = '{1'b0, 1'b1, 1'b0};
    preset = 8'h01; load = 1'b1; up = 1'b0; enable = 1'b0;
    tick();
    n_checks++; if (count_w !== 8'h01) begin n_fail++; $display("FAIL down_load_w got=%h exp=01", count_w); end
    n_checks++; if (count_h !== 8'h01) begin n_fail++; $display("FAIL down_load_h got=%h exp=01", count_h); end
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (count_w !== exp_c[i]) begin n_fail++; $display("FAIL down_count_w[%0d] got=%h exp=%h", i, count_w, exp_c[i]); end
      n_checks++; if (wrap_w !== exp_w[i]) begin n_fail++; $display("FAIL down_wrap_w[%0d] got=%b exp=%b", i, wrap_w, exp_w[i]); end
      n_checks++; if (count_h !== 8'h00) begin n_fail++; $display("FAIL hold_count_h[%0d] got=%h exp=00", i, count_h); end
      n_checks++; if (terminal_h !== 1'b1) begin n_fail++; $display("FAIL hold_terminal_h[%0d] got=%b exp=1", i, terminal_h); end
      n_checks++; if (wrap_h !== 1'b0) begin n_fail++; $display("FAIL hold_wrap_h[%0d] got=%b exp=0", i, wrap_h); end
    end
    enable = 1'b0;
  endtask

  task automatic test_invalid_preset();
    logic [7:0] bad [2] = '{8'h3A, 8'h30};
    for (int i = 0; i < 2; i++) begin
      preset = bad[i]; load = 1'b1;
      tick();
      n_checks++; if (count_w !== 8'h28) begin n_fail++; $display("FAIL bad_load_count[%0d] got=%h exp=28", i, count_w); end
      n_checks++; if (load_err_w !== 1'b1) begin n_fail++; $display("FAIL bad_load_err[%0d] got=%b exp=1", i, load_err_w); end
      load = 1'b0;
      tick();
      n_checks++; if (load_err_w !== 1'b0) begin n_fail++; $display("FAIL bad_load_err_pulse[%0d] got=%b exp=0", i, load_err_w); end
      n_checks++; if (count_w !== 8'h28) begin n_fail++; $display("FAIL bad_load_hold[%0d] got=%h exp=28", i, count_w); end
    end
    preset = 8'h19; load = 1'b1;
    tick();
    n_checks++; if (count_w !== 8'h19) begin n_fail++; $display("FAIL good_load_count got=%h exp=19", count_w); end
    n_checks++; if (load_err_w !== 1'b0) begin n_fail++; $display("FAIL good_load_err got=%b exp=0", load_err_w); end
    load = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    preset = 8'h12; load = 1'b1; enable = 1'b1; up = 1'b1;
    tick();
    n_checks++; if (count_w !== 8'h12) begin n_fail++; $display("FAIL load_over_enable got=%h exp=12", count_w); end
    load = 1'b0;
    tick();
    n_checks++; if (count_w !== 8'h13) begin n_fail++; $display("FAIL count_after_load got=%h exp=13", count_w); end
    enable = 1'b0; preset = 8'h05; load = 1'b1; reset = 1'b1;
    tick();
    n_checks++; if (count_w !== 8'h00) begin n_fail++; $display("FAIL reset_over_load got=%h exp=00", count_w); end
    reset = 1'b0;
    tick();
    n_checks++; if (count_w !== 8'h05) begin n_fail++; $display("FAIL load_after_reset got=%h exp=05", count_w); end
    load = 1'b0; preset = 8'h17;
    tick();
    load = 1'b1;
    tick();
    n_checks++; if (count_w !== 8'h17) begin n_fail++; $display("FAIL load_17 got=%h exp=17", count_w); end
    load = 1'b0; enable = 1'b1; reset = 1'b1;
    tick();
    n_checks++; if (count_w !== 8'h00) begin n_fail++; $display("FAIL reset_mid_count got=%h exp=00", count_w); end
    n_checks++; if (wrap_w !== 1'b0) begin n_fail++; $display("FAIL reset_mid_wrap got=%b exp=0", wrap_w); end
    reset = 1'b0; enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_held();
    test_count_up_wrap();
    test_count_down_wrap_hold();
    test_invalid_preset();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
